// File: rtl/riscv_apu_resp_alu.sv
// APU responder: credit-controlled grant, fixed-latency pipelined ALU, and an
// in-order result FIFO with valid/ready backpressure.
module riscv_apu_resp_alu #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             apu_req_i,
    output logic             apu_gnt_o,
    input  logic [1:0]       apu_op_i,
    input  logic [WIDTH-1:0] apu_opa_i,
    input  logic [WIDTH-1:0] apu_opb_i,
    input  logic [TAG_W-1:0] apu_tag_i,
    output logic             apu_valid_o,
    input  logic             apu_ready_i,
    output logic [WIDTH-1:0] apu_result_o,
    output logic [TAG_W-1:0] apu_tag_o,
    output logic             busy_o,
    output logic             perf_stall_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0] occ;
    logic             accept;
    logic             pop;
    logic [WIDTH-1:0] alu_res;

    logic             fifo_wr;
    logic [WIDTH-1:0] fifo_wr_res;
    logic [TAG_W-1:0] fifo_wr_tag;

    logic [WIDTH-1:0] mem_res [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_empty;
    logic             fifo_full;

    // Grant is a pure compare on the registered credit count; no pop lookahead.
    assign apu_gnt_o    = !rst_i && (occ < CNT_W'(DEPTH));
    assign accept       = apu_req_i && apu_gnt_o;
    assign pop          = apu_valid_o && apu_ready_i;
    assign busy_o       = (occ != '0);
    assign perf_stall_o = apu_req_i && !apu_gnt_o;

    always_comb begin
        alu_res = '0;
        case (apu_op_i)
            2'b00:   alu_res = apu_opa_i + apu_opb_i;
            2'b01:   alu_res = apu_opa_i - apu_opb_i;
            2'b10:   alu_res = apu_opa_i ^ apu_opb_i;
            default: alu_res = apu_opa_i * apu_opb_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // LAT-1 register stages between compute and the FIFO write port.
    generate
        if (LAT == 1) begin : g_direct
            assign fifo_wr     = accept;
            assign fifo_wr_res = alu_res;
            assign fifo_wr_tag = apu_tag_i;
        end else begin : g_pipe
            logic [LAT-2:0]   stg_valid;
            logic [WIDTH-1:0] stg_res [LAT-1];
            logic [TAG_W-1:0] stg_tag [LAT-1];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    stg_valid <= '0;
                    for (int i = 0; i < LAT - 1; i++) begin
                        stg_res[i] <= '0;
                        stg_tag[i] <= '0;
                    end
                end else begin
                    stg_valid[0] <= accept;
                    stg_res[0]   <= alu_res;
                    stg_tag[0]   <= apu_tag_i;
                    for (int i = 1; i < LAT - 1; i++) begin
                        stg_valid[i] <= stg_valid[i-1];
                        stg_res[i]   <= stg_res[i-1];
                        stg_tag[i]   <= stg_tag[i-1];
                    end
                end
            end

            assign fifo_wr     = stg_valid[LAT-2];
            assign fifo_wr_res = stg_res[LAT-2];
            assign fifo_wr_tag = stg_tag[LAT-2];
        end
    endgenerate

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CNT_W'(DEPTH));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_res[i] <= '0;
                mem_tag[i] <= '0;
            end
        end else begin
            if (fifo_wr) begin
                mem_res[wr_ptr] <= fifo_wr_res;
                mem_tag[wr_ptr] <= fifo_wr_tag;
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({fifo_wr, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Head is read combinationally; a same-cycle write into an empty FIFO is not bypassed.
    assign apu_valid_o  = !fifo_empty;
    assign apu_result_o = fifo_empty ? '0 : mem_res[rd_ptr];
    assign apu_tag_o    = fifo_empty ? '0 : mem_tag[rd_ptr];

    a_fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(fifo_wr && fifo_full && !pop));

    a_fifo_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(pop && fifo_empty));

    a_hold_under_backpressure: assert property (@(posedge clk_i) disable iff (rst_i)
        (apu_valid_o && !apu_ready_i) |=>
        (apu_valid_o && $stable(apu_result_o) && $stable(apu_tag_o)));

endmodule

// File: tb/tb_riscv_apu_resp_alu.sv
// Self-checking bench for riscv_apu_resp_alu: directed scenarios plus random
// traffic, all checked every cycle against a queue-based transaction model.
module tb_riscv_apu_resp_alu;

    localparam int WIDTH = 32;
    localparam int TAG_W = 6;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req = 1'b0;
    logic             gnt;
    logic [1:0]       op = '0;
    logic [WIDTH-1:0] opa = '0;
    logic [WIDTH-1:0] opb = '0;
    logic [TAG_W-1:0] tag_in = '0;
    logic             valid;
    logic             ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag_out;
    logic             busy;
    logic             stall;

    riscv_apu_resp_alu #(.WIDTH(WIDTH), .TAG_W(TAG_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .apu_req_i    (req),
        .apu_gnt_o    (gnt),
        .apu_op_i     (op),
        .apu_opa_i    (opa),
        .apu_opb_i    (opb),
        .apu_tag_i    (tag_in),
        .apu_valid_o  (valid),
        .apu_ready_i  (ready),
        .apu_result_o (result),
        .apu_tag_o    (tag_out),
        .busy_o       (busy),
        .perf_stall_o (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [TAG_W-1:0] tag;
        int               due;
    } ent_t;

    ent_t q[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_alu(input logic [1:0] o, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] prod;
        case (o)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a ^ b;
            default: begin
                prod = a * b;
                return prod[WIDTH-1:0];
            end
        endcase
    endfunction

    // One clock cycle: drive inputs at a negedge, check all outputs, advance the model.
    task automatic step(input logic r, input logic [1:0] o, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t, input logic rdy);
        logic exp_gnt, exp_valid;
        ent_t e;
        req = r; op = o; opa = a; opb = b; tag_in = t; ready = rdy;
        #1;
        exp_gnt   = (q.size() < DEPTH);
        exp_valid = (q.size() > 0) && (q[0].due <= cyc);
        chk("gnt", 64'(gnt), 64'(exp_gnt));
        chk("valid", 64'(valid), 64'(exp_valid));
        chk("busy", 64'(busy), 64'(q.size() != 0));
        chk("stall", 64'(stall), 64'(r && !exp_gnt));
        if (exp_valid) begin
            chk("result", 64'(result), 64'(q[0].res));
            chk("tag", 64'(tag_out), 64'(q[0].tag));
        end
        if (exp_valid && rdy) void'(q.pop_front());
        if (r && exp_gnt) begin
            e.res = ref_alu(o, a, b);
            e.tag = t;
            e.due = cyc + LAT;
            q.push_back(e);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, '0, '0, rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0; ready = 1'b0;
        #1;
        chk("rst_valid", 64'(valid), 64'(0));
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_tag", 64'(tag_out), 64'(0));
        @(negedge clk);
        chk("rst_hold_valid", 64'(valid), 64'(0));
        rst = 1'b0;
        q.delete();
        #1;
        chk("post_rst_gnt", 64'(gnt), 64'(1));
        chk("post_rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        cyc += 2;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Reset with ops in flight: nothing may come back afterwards.
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 32'(i), 32'd1, 6'(i), 1'b0);
        do_reset();
        idle(4, 1'b1);

        // Single add with observable latency.
        step(1'b1, 2'd0, 32'd5, 32'd3, 6'd7, 1'b1);
        idle(4, 1'b1);

        // Streaming with ready held high.
        for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 32'(i * 3), 32'(i), 6'(i), 1'b1);
        idle(4, 1'b1);

        // Backpressure: fill credits, then drain while requests continue.
        for (int i = 0; i < 10; i++) step(1'b1, 2'd1, 32'(100 + i), 32'(i), 6'(16 + i), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 2'd2, 32'(i), 32'hFF, 6'(32 + i), 1'b1);
        idle(6, 1'b1);

        // Arithmetic corners.
        step(1'b1, 2'd1, 32'h0, 32'h1, 6'd1, 1'b1);
        step(1'b1, 2'd3, 32'h10000, 32'h10000, 6'd2, 1'b1);
        step(1'b1, 2'd2, 32'hA5A5A5A5, 32'hFFFFFFFF, 6'd3, 1'b1);
        step(1'b1, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd4, 1'b1);
        step(1'b1, 2'd0, 32'hFFFFFFFF, 32'h1, 6'd5, 1'b1);
        idle(4, 1'b1);

        // Occupancy 3 then simultaneous accept and pop.
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 32'(i), 32'd10, 6'(40 + i), 1'b0);
        step(1'b0, 2'd0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 32'(i), 32'd20, 6'(50 + i), 1'b1);
        idle(6, 1'b1);

        // Random traffic with varying request/ready densities.
        for (int phase = 0; phase < 4; phase++) begin
            for (int i = 0; i < 150; i++) begin
                step(($urandom_range(0, 3) < phase + 1),
                     2'($urandom_range(0, 3)),
                     (($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'($urandom)),
                     (($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom)),
                     6'($urandom_range(0, 63)),
                     ($urandom_range(0, 3) < 4 - phase));
            end
            idle(DEPTH + LAT + 2, 1'b1);
        end

        // Reset in the middle of random traffic.
        for (int i = 0; i < 5; i++) step(1'b1, 2'd3, 32'($urandom), 32'($urandom), 6'(i), 1'b0);
        do_reset();
        idle(5, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
